period_meter: RTL
=================

PERIOD_METER -- requirements
Module: period_meter

Interface
REQ-001: Parameter CNT_W, default 24, counter and result width in bits.
REQ-002: Parameter TIMEOUT, default 24'd10_000_000, number of clk_in cycles without an edge before no_signal is declared; legal range 2..2^CNT_W-1.
REQ-003: Parameter SYNC_STAGES, default 2, number of synchronizer flops on pulse_in; minimum 2.
REQ-004: clk_in  input  1  single system clock; all state changes on its rising edge.
REQ-005: rst_n  input  1  asynchronous, active-low reset.
REQ-006: pulse_in  input  1  asynchronous pulse train to be measured.
REQ-007: en  input  1  measurement enable; low forces IDLE.
REQ-008: period  output  CNT_W  last captured rising-edge-to-rising-edge interval, in clk_in cycles.
REQ-009: period_valid  output  1  period holds an unconsumed result.
REQ-010: period_ready  input  1  consumer accepts the result when high together with period_valid.
REQ-011: no_signal  output  1  level; high while no rising edge has arrived within TIMEOUT cycles.
REQ-012: overrun  output  1  sticky; a measurement was dropped because the result slot was full.

Function
REQ-013: pulse_in shall pass through SYNC_STAGES flops and then one edge-detect flop; a rising edge is the condition synced=1 and previous=0.
REQ-014: FSM states: IDLE, ARM, MEASURE.
REQ-015: IDLE: counter held at 0; en=1 -> ARM on the next cycle.
REQ-016: ARM: on a rising edge, counter loads 1 -> MEASURE; otherwise counter increments.
REQ-017: MEASURE: on a rising edge, counter value becomes the candidate result, counter reloads 1, state stays MEASURE; otherwise counter increments.
REQ-018: Measured period = clk_in cycles between two consecutive detected rising edges (edges at cycles t0 and t1 give period = t1 - t0).
REQ-019: Latency: with SYNC_STAGES=2, a pulse_in rise sampled at clk_in edge k shall show period/period_valid updated after edge k+2.
REQ-020: Result slot: when period_valid=0, or when period_valid=1 and period_ready=1 in the same cycle, the candidate loads period and period_valid stays or goes 1.
REQ-021: When period_valid=1, period_ready=0 and a candidate arrives, the candidate shall be dropped, period shall stay unchanged, and overrun shall be set.
REQ-022: period_valid=1, period_ready=1 and no candidate: period_valid shall clear next cycle; period shall hold its value.
REQ-023: Timeout in ARM or MEASURE: when the counter reaches TIMEOUT with no edge, no_signal shall be set, the counter shall reload 0 and the FSM shall go to ARM; the counter shall never wrap.
REQ-024: no_signal shall clear on the next detected rising edge.
REQ-025: en low in any state: next cycle IDLE, counter 0, no_signal 0; period, period_valid and overrun unaffected (the consumer can still drain the result).
REQ-026: overrun shall clear only on reset or on an en 0->1 transition.
REQ-027: An edge in the same cycle as the timeout condition shall be treated as an edge; no timeout occurs.

Reset
REQ-028: rst_n low shall asynchronously force state IDLE, all synchronizer and edge flops 0, counter 0, period 0, period_valid 0, no_signal 0, overrun 0.
REQ-029: Reset deassertion mid-pulse-train shall produce no result until two fresh rising edges have been detected.

Structure
REQ-030: Package period_meter_pkg shall hold the state enum (IDLE, ARM, MEASURE) and the default CNT_W and TIMEOUT constants.
REQ-031: Sub-module sync_edge shall contain the synchronizer chain and the rising-edge detector, with outputs synced level and rise pulse.
REQ-032: Target size is 150-300 lines of RTL in total.

Verification
REQ-033: en=1, square wave with period 100 cycles, period_ready=1 -> the first result is 100, and every 100 cycles afterwards period_valid pulses with period=100.
REQ-034: TIMEOUT=1000, pulse_in held low after one edge -> no_signal rises 1000 cycles after the edge; the next edge clears it with no result; the second edge gives a valid result.
REQ-035: period_ready=0, pulse period 50 -> the first result is 50, held; the second candidate is dropped and overrun=1; raising period_ready drains 50, and the next result loads.
REQ-036: en dropped mid-MEASURE and re-raised -> no result is produced from the pre-drop edge, and overrun is cleared by the rising en.
REQ-037: rst_n pulsed low mid-measurement with period_valid=1 -> all outputs are 0 immediately, without waiting for a clock edge.
REQ-038: Edge coincident with a counter value of TIMEOUT -> period=TIMEOUT is captured and no_signal stays 0.

Source files
------------

// File: rtl/period_meter_pkg.sv
// period_meter_pkg: shared types and defaults for the period meter.
//   state_t      - measurement FSM states
//   DEF_CNT_W    - default counter / result width
//   DEF_TIMEOUT  - default no-signal timeout in clk_in cycles
package period_meter_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARM     = 2'd1,
    MEASURE = 2'd2
  } state_t;

  localparam int          DEF_CNT_W   = 24;
  localparam int unsigned DEF_TIMEOUT = 32'd10_000_000;

endpackage

// File: rtl/period_meter_if.sv
// period_meter_if: result handshake between the meter and its consumer.
//   period       - captured interval in clk_in cycles
//   period_valid - period holds an unconsumed result
//   period_ready - consumer accepts the result this cycle
// master = meter side, slave = consumer side.
interface period_meter_if
  import period_meter_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
);
  logic [CNT_W-1:0] period;
  logic             period_valid;
  logic             period_ready;

  modport master (output period, output period_valid, input  period_ready);
  modport slave  (input  period, input  period_valid, output period_ready);
endinterface

// File: rtl/period_meter_sync_edge.sv
// sync_edge: brings the asynchronous pulse into clk_in and flags rising edges.
//   clk_in   - system clock
//   rst_n    - async active-low reset, clears every flop
//   i_pulse  - asynchronous pulse input
//   o_synced - synchronized level (last synchronizer stage)
//   o_rise   - one-cycle pulse: synced level high, previous level low
// SYNC_STAGES must be at least 2.
module sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_in,
  input  logic rst_n,
  input  logic i_pulse,
  output logic o_synced,
  output logic o_rise
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= '0;
      r_prev <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_pulse};
      r_prev <= r_sync[SYNC_STAGES-1];
    end
  end

  assign o_synced = r_sync[SYNC_STAGES-1];
  assign o_rise   = r_sync[SYNC_STAGES-1] & ~r_prev;

endmodule

// File: rtl/period_meter.sv
// period_meter: measures rising-edge-to-rising-edge interval of pulse_in.
//   clk_in     - system clock, all state changes on its rising edge
//   rst_n      - async active-low reset
//   pulse_in   - asynchronous pulse train
//   en         - measurement enable; low parks the FSM in IDLE
//   no_signal  - no edge within TIMEOUT cycles (cleared by next edge / en low)
//   overrun    - sticky: a result was dropped because the slot was full
//   res        - result handshake (period / period_valid / period_ready)
// With SYNC_STAGES=2 a rise sampled at edge k updates the result after edge k+2.
module period_meter
  import period_meter_pkg::*;
#(
  parameter int          CNT_W       = DEF_CNT_W,
  parameter int unsigned TIMEOUT     = DEF_TIMEOUT,
  parameter int          SYNC_STAGES = 2
) (
  input  logic                  clk_in,
  input  logic                  rst_n,
  input  logic                  pulse_in,
  input  logic                  en,
  output logic                  no_signal,
  output logic                  overrun,
  period_meter_if.master        res
);

  localparam logic [CNT_W-1:0] TO_CNT = CNT_W'(TIMEOUT);

  logic             w_synced;
  logic             w_rise;
  logic             w_edge;

  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic             r_nosig, w_nosig_nxt;
  logic             w_cand_vld;

  logic [CNT_W-1:0] r_period;
  logic             r_valid;
  logic             r_overrun;
  logic             r_en_q;

  sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk_in   (clk_in),
    .rst_n    (rst_n),
    .i_pulse  (pulse_in),
    .o_synced (w_synced),
    .o_rise   (w_rise)
  );

  assign w_edge = w_rise & w_synced;

  // ---------------- FSM + counter ----------------
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_nosig <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_nosig <= w_nosig_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_nosig_nxt = r_nosig;
    w_cand_vld  = 1'b0;
    if (!en) begin
      w_state_nxt = IDLE;
      w_cnt_nxt   = '0;
      w_nosig_nxt = 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          w_state_nxt = ARM;
          w_cnt_nxt   = '0;
        end
        ARM, MEASURE: begin
          // An edge wins over a coincident timeout.
          if (w_edge) begin
            w_state_nxt = MEASURE;
            w_cnt_nxt   = CNT_W'(1);
            w_nosig_nxt = 1'b0;
            // Only an edge that closes an interval yields a result.
            w_cand_vld  = (r_state == MEASURE);
          end else if (r_cnt == TO_CNT) begin
            w_state_nxt = ARM;
            w_cnt_nxt   = '0;
            w_nosig_nxt = 1'b1;
          end else begin
            w_cnt_nxt   = r_cnt + CNT_W'(1);
          end
        end
        default: begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
        end
      endcase
    end
  end

  // ---------------- result slot ----------------
  // en only gates measuring; the slot keeps draining while en is low.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      r_period  <= '0;
      r_valid   <= 1'b0;
      r_overrun <= 1'b0;
      r_en_q    <= 1'b0;
    end else begin
      r_en_q <= en;
      if (w_cand_vld) begin
        if (!r_valid || res.period_ready) begin
          r_period <= r_cnt;
          r_valid  <= 1'b1;
        end else begin
          r_overrun <= 1'b1;
        end
      end else if (r_valid && res.period_ready) begin
        r_valid <= 1'b0;
      end
      if (en && !r_en_q) r_overrun <= 1'b0;
    end
  end

  assign res.period       = r_period;
  assign res.period_valid = r_valid;
  assign no_signal        = r_nosig;
  assign overrun          = r_overrun;

endmodule
